sched_demux32_8: RTL
====================

SCHED_DEMUX32_8 -- requirements
Module: sched_demux32_8

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 1, where 1 means byte order [31:24],[23:16],[15:8],[7:0] and 0 means the reverse.
REQ-002 The block SHALL have port clk_4f  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_L  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have ports data_in0..data_in3  input  32 each  word from requester 0..3.
REQ-005 The block SHALL have port valid_in  input  4  bit i set means data_in<i> holds a word.
REQ-006 The block SHALL have port ready_out  output  4  bit i set means requester i's word is accepted this edge; combinational.
REQ-007 The block SHALL have port data_out  output  8  serialized byte; registered.
REQ-008 The block SHALL have port valid_out  output  1  data_out carries a valid byte; registered.
REQ-009 The block SHALL have port lane_out  output  2  index of the requester owning the current byte; registered.
REQ-010 The block SHALL have port busy  output  1  high while in SEND; registered.

Function
REQ-011 The block SHALL implement two states: IDLE and SEND.
REQ-012 A 2-bit byte counter SHALL count 0..3 in SEND and wrap 3->0.
REQ-013 In IDLE, or in SEND with counter==3, ready_out SHALL be one-hot on the granted lane if any valid_in bit is set, else 0; otherwise ready_out SHALL be 0.
REQ-014 The grant SHALL be round-robin: search lanes starting at (last_grant+1) mod 4, upward with wrap; the first lane with valid_in set wins.
REQ-015 A handshake SHALL occur at a rising edge where valid_in[i] and ready_out[i] are both 1; the block SHALL capture data_in<i> into a 32-bit shift register, set last_grant=i, clear counter to 0, and enter or stay in SEND.
REQ-016 A requester SHALL hold data_in<i> stable while valid_in[i]=1 and ready_out[i]=0; the block SHALL not sample unaccepted words.
REQ-017 Latency: the first byte SHALL appear on data_out, with valid_out=1 and lane_out=i, in the cycle immediately after the handshake edge.
REQ-018 In SEND, one byte per cycle SHALL be emitted in MSB_FIRST order for 4 consecutive cycles; lane_out SHALL stay constant for the word.
REQ-019 At counter==3 with no valid_in set, the next state SHALL be IDLE, with valid_out=0, data_out=8'h00, and busy=0.
REQ-020 At counter==3 with any valid_in set, the next word SHALL load back-to-back with no idle cycle between the last byte and the next first byte.
REQ-021 Whenever valid_out=0, data_out SHALL be 8'h00.
REQ-022 valid_in changes during SEND with counter!=3 SHALL have no effect on the current word.
REQ-023 A requester that deasserts valid_in before being granted SHALL lose its request; no request memory SHALL be kept.

Reset
REQ-024 While reset_L=0, the block SHALL force immediately, regardless of clock: state IDLE, counter 0, shift register 0, last_grant=3, data_out=8'h00, valid_out=0, lane_out=0, busy=0, ready_out=0.
REQ-025 A word in flight at reset assertion SHALL be discarded; after reset_L rises, lane 0 SHALL have first priority.
REQ-026 The first handshake SHALL occur no earlier than the first rising edge of clk_4f after reset_L rises.

Verification
REQ-027 Single word: lane 0 only valid with 32'h2E9F1305 -> ready_out=4'b0001 for one edge; next 4 cycles data_out=2E,9F,13,05, lane_out=0, valid_out=1; then IDLE with data_out=00.
REQ-028 All four lanes valid continuously with distinct words -> grant order 0,1,2,3,0; 16+ contiguous valid_out cycles with no bubble; lane_out changes every 4 cycles.
REQ-029 Fairness: after lane 2 is served, lanes 0 and 3 both valid -> lane 3 is granted before lane 0.
REQ-030 Reset mid-word: reset_L low after byte 2 of a lane-1 word -> outputs zero asynchronously; after release, lanes 0 and 1 both valid -> lane 0 is granted first.
REQ-031 MSB_FIRST=0 with lane 3 word 32'h2E9F1305 -> bytes 05,13,9F,2E with lane_out=3.
REQ-032 A valid pulse on lane 2 only during counter 1 of a lane-0 word, dropped before counter==3 -> no grant to lane 2; return to IDLE.

Source files
------------

// File: rtl/sched_demux32_8.sv
// Four-requester round-robin scheduler that serializes one accepted 32-bit word
// into four consecutive registered bytes, reloading back-to-back on the last byte.
module sched_demux32_8 #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk_4f,
  input  logic        reset_L,
  input  logic [31:0] data_in0,
  input  logic [31:0] data_in1,
  input  logic [31:0] data_in2,
  input  logic [31:0] data_in3,
  input  logic [3:0]  valid_in,
  output logic [3:0]  ready_out,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic [1:0]  lane_out,
  output logic        busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        valid_out_q, valid_out_d;
  logic [1:0]  lane_out_q, lane_out_d;
  logic        busy_q, busy_d;

  logic [1:0]  scan_start;
  logic [1:0]  scan_idx;
  logic [1:0]  grant_idx;
  logic        grant_found;
  logic        accept_window;
  logic        handshake;
  logic [31:0] sel_word;

  // Round-robin search begins one past the previous winner and wraps.
  always_comb begin
    scan_start  = last_grant_q + 2'd1;
    scan_idx    = 2'd0;
    grant_idx   = 2'd0;
    grant_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = scan_start + 2'(k);
      if (!grant_found && valid_in[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign accept_window = (state_q == IDLE) || (cnt_q == 2'd3);
  assign handshake     = accept_window && grant_found && reset_L;
  assign ready_out     = handshake ? (4'b0001 << grant_idx) : 4'b0000;

  always_comb begin
    sel_word = data_in0;
    case (grant_idx)
      2'd0:    sel_word = data_in0;
      2'd1:    sel_word = data_in1;
      2'd2:    sel_word = data_in2;
      default: sel_word = data_in3;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    last_grant_d = last_grant_q;
    data_out_d   = data_out_q;
    valid_out_d  = valid_out_q;
    lane_out_d   = lane_out_q;
    busy_d       = busy_q;

    if (handshake) begin
      // First byte goes straight to the output; the rest wait in the shifter.
      state_d      = SEND;
      cnt_d        = 2'd0;
      last_grant_d = grant_idx;
      lane_out_d   = grant_idx;
      valid_out_d  = 1'b1;
      busy_d       = 1'b1;
      if (MSB_FIRST) begin
        data_out_d = sel_word[31:24];
        shift_d    = {sel_word[23:0], 8'h00};
      end else begin
        data_out_d = sel_word[7:0];
        shift_d    = {8'h00, sel_word[31:8]};
      end
    end else if (state_q == SEND) begin
      if (cnt_q == 2'd3) begin
        state_d     = IDLE;
        cnt_d       = 2'd0;
        valid_out_d = 1'b0;
        busy_d      = 1'b0;
        data_out_d  = 8'h00;
      end else begin
        cnt_d = cnt_q + 2'd1;
        if (MSB_FIRST) begin
          data_out_d = shift_q[31:24];
          shift_d    = {shift_q[23:0], 8'h00};
        end else begin
          data_out_d = shift_q[7:0];
          shift_d    = {8'h00, shift_q[31:8]};
        end
      end
    end
  end

  // last_grant resets to 3 so lane 0 is searched first after reset.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      shift_q      <= 32'h0;
      last_grant_q <= 2'd3;
      data_out_q   <= 8'h00;
      valid_out_q  <= 1'b0;
      lane_out_q   <= 2'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      last_grant_q <= last_grant_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      lane_out_q   <= lane_out_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign lane_out  = lane_out_q;
  assign busy      = busy_q;

endmodule
